device_io_regs: RTL and testbench



---
 rtl/device_io_pkg.sv | 12 +
 rtl/device_io_if.sv | 23 ++
 rtl/io_debounce.sv | 51 +++++
 rtl/device_io_regs.sv | 112 +++++++++++
 tb/tb_device_io_regs.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/device_io_pkg.sv
// rtl/device_io_pkg.sv - register offsets shared by the device I/O block
package device_io_pkg;

    localparam logic [3:0] REG_LED    = 4'h0;
    localparam logic [3:0] REG_SEG    = 4'h1;
    localparam logic [3:0] REG_SW     = 4'h2;
    localparam logic [3:0] REG_BTN    = 4'h3;
    localparam logic [3:0] REG_EDGE   = 4'h4;
    localparam logic [3:0] REG_IRQ_EN = 4'h5;
    localparam logic [3:0] REG_TIMER  = 4'h6;

endpackage

// File: rtl/device_io_if.sv
// rtl/device_io_if.sv - CPU-side register bus of the device I/O block
interface device_io_if;

    logic [7:0]  device_io_addr;
    logic [31:0] device_io_write_data;
    logic        device_io_wen;
    logic [31:0] device_io_read_data;

    modport master (
        output device_io_addr,
        output device_io_write_data,
        output device_io_wen,
        input  device_io_read_data
    );

    modport slave (
        input  device_io_addr,
        input  device_io_write_data,
        input  device_io_wen,
        output device_io_read_data
    );

endinterface

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - 2-FF synchroniser plus per-bit stability counter
module io_debounce #(
    parameter int          WIDTH      = 1,
    parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [15:0]      cnt_q [WIDTH];
    logic [15:0]      cnt_d [WIDTH];

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // counter only runs while the synchronised level disagrees
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_CYCLES - 16'd1) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/device_io_regs.sv
// rtl/device_io_regs.sv - LED/SEG registers, debounced inputs, edge IRQ and cycle timer
module device_io_regs
    import device_io_pkg::*;
#(
    parameter int          SW_WIDTH   = 16,
    parameter int          LED_WIDTH  = 16,
    parameter int          BTN_COUNT  = 20,
    parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
    input  logic                 clk,
    input  logic                 rst,
    device_io_if.slave           bus,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic [BTN_COUNT-1:0] btn,
    output logic [LED_WIDTH-1:0] led_out,
    output logic [31:0]          seg_text,
    output logic                 irq
);

    logic [SW_WIDTH-1:0]  sw_deb;
    logic [BTN_COUNT-1:0] btn_deb;

    io_debounce #(.WIDTH(SW_WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
        .clk(clk), .rst(rst), .din(sw), .dout(sw_deb)
    );

    io_debounce #(.WIDTH(BTN_COUNT), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
        .clk(clk), .rst(rst), .din(btn), .dout(btn_deb)
    );

    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          seg_q, seg_d;
    logic [BTN_COUNT-1:0] irq_en_q, irq_en_d;
    logic [BTN_COUNT-1:0] edge_q, edge_d;
    logic [BTN_COUNT-1:0] btn_prev_q, btn_prev_d;
    logic [31:0]          timer_q, timer_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 irq_q, irq_d;

    logic [3:0]           sel;
    logic [31:0]          wdata;
    logic                 wen;
    logic [BTN_COUNT-1:0] edge_clr;
    logic                 unused_addr_bits;

    assign sel              = bus.device_io_addr[7:4];
    assign wdata            = bus.device_io_write_data;
    assign wen              = bus.device_io_wen;
    assign unused_addr_bits = ^bus.device_io_addr[3:0];

    always_comb begin
        led_d      = led_q;
        seg_d      = seg_q;
        irq_en_d   = irq_en_q;
        edge_clr   = '0;
        timer_d    = timer_q + 32'd1;
        btn_prev_d = btn_deb;
        if (wen) begin
            case (sel)
                REG_LED:    led_d    = wdata[LED_WIDTH-1:0];
                REG_SEG:    seg_d    = wdata;
                REG_EDGE:   edge_clr = wdata[BTN_COUNT-1:0];
                REG_IRQ_EN: irq_en_d = wdata[BTN_COUNT-1:0];
                REG_TIMER:  timer_d  = wdata;
                default:    ;
            endcase
        end
        // a fresh rising edge overrides a simultaneous write-1-to-clear
        edge_d = (edge_q & ~edge_clr) | (btn_deb & ~btn_prev_q);
        irq_d  = |(edge_q & irq_en_q);

        rd_data_d = '0;
        case (sel)
            REG_LED:    rd_data_d[LED_WIDTH-1:0] = led_q;
            REG_SEG:    rd_data_d                = seg_q;
            REG_SW:     rd_data_d[SW_WIDTH-1:0]  = sw_deb;
            REG_BTN:    rd_data_d[BTN_COUNT-1:0] = btn_deb;
            REG_EDGE:   rd_data_d[BTN_COUNT-1:0] = edge_q;
            REG_IRQ_EN: rd_data_d[BTN_COUNT-1:0] = irq_en_q;
            REG_TIMER:  rd_data_d                = timer_q;
            default:    rd_data_d                = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= '0;
            seg_q      <= '0;
            irq_en_q   <= '0;
            edge_q     <= '0;
            btn_prev_q <= '0;
            timer_q    <= '0;
            rd_data_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            led_q      <= led_d;
            seg_q      <= seg_d;
            irq_en_q   <= irq_en_d;
            edge_q     <= edge_d;
            btn_prev_q <= btn_prev_d;
            timer_q    <= timer_d;
            rd_data_q  <= rd_data_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.device_io_read_data = rd_data_q;
    assign led_out                 = led_q;
    assign seg_text                = seg_q;
    assign irq                     = irq_q;

endmodule

// File: tb/tb_device_io_regs.sv
// tb/tb_device_io_regs.sv - directed-vector bench for device_io_regs
module tb_device_io_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [19:0] btn;
    logic [15:0] led_out;
    logic [31:0] seg_text;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    device_io_if bus ();

    device_io_regs #(
        .SW_WIDTH(16), .LED_WIDTH(16), .BTN_COUNT(20), .DEB_CYCLES(16'd4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw(sw), .btn(btn),
        .led_out(led_out), .seg_text(seg_text), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.device_io_addr       = a;
        bus.device_io_write_data = d;
        bus.device_io_wen        = 1'b1;
        tick();
        bus.device_io_wen        = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.device_io_addr = a;
        bus.device_io_wen  = 1'b0;
        tick();
        check(tag, bus.device_io_read_data, exp);
    endtask

    logic [31:0] timer_exp [4];

    initial begin
        timer_exp[0] = 32'hFFFF_FFFE;
        timer_exp[1] = 32'hFFFF_FFFF;
        timer_exp[2] = 32'h0000_0000;
        timer_exp[3] = 32'h0000_0001;

        rst                      = 1'b1;
        sw                       = '0;
        btn                      = '0;
        bus.device_io_addr       = 8'h60;
        bus.device_io_write_data = '0;
        bus.device_io_wen        = 1'b0;

        // reset: timer held, write coincident with reset is lost
        repeat (5) tick();
        check("timer_in_reset", bus.device_io_read_data, 32'h0);
        bus.device_io_addr       = 8'h00;
        bus.device_io_write_data = 32'h0000_FFFF;
        bus.device_io_wen        = 1'b1;
        tick();
        bus.device_io_wen = 1'b0;
        rst               = 1'b0;
        check("irq_reset", {31'b0, irq}, 32'h0);
        check("led_out_reset", {16'b0, led_out}, 32'h0);
        check("seg_text_reset", seg_text, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (i != 6) rd_chk($sformatf("reset_rd_%0h0", i), 8'(i << 4), 32'h0);
        end

        // LED write: same-cycle read returns old value
        wr(8'h00, 32'hFFFF_A5A5);
        check("led_same_cycle_rd", bus.device_io_read_data, 32'h0);
        check("led_out", {16'b0, led_out}, 32'h0000_A5A5);
        rd_chk("led_rd", 8'h00, 32'h0000_A5A5);
        wr(8'h10, 32'h1234_5678);
        check("seg_text", seg_text, 32'h1234_5678);
        rd_chk("seg_rd", 8'h10, 32'h1234_5678);

        // switch debounce: 2 sync + 4 stable cycles, then one read cycle
        bus.device_io_addr = 8'h20;
        sw = 16'h0001;
        repeat (6) tick();
        check("sw_deb_pending", bus.device_io_read_data, 32'h0);
        tick();
        check("sw_deb_settled", bus.device_io_read_data, 32'h0000_0001);
        sw = 16'h0003;
        repeat (3) tick();
        sw = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("sw_glitch_%0d", i), bus.device_io_read_data, 32'h0000_0001);
        end

        // button edge and interrupt
        wr(8'h50, 32'h0000_0008);
        bus.device_io_addr = 8'h40;
        btn = 20'h00008;
        repeat (7) tick();
        check("edge_rd_pending", bus.device_io_read_data, 32'h0);
        check("irq_pending", {31'b0, irq}, 32'h0);
        tick();
        check("edge_rd_set", bus.device_io_read_data, 32'h0000_0008);
        check("irq_set", {31'b0, irq}, 32'h1);
        rd_chk("btn_rd", 8'h30, 32'h0000_0008);

        wr(8'h40, 32'h0000_0008);
        check("edge_clr_same_cycle_rd", bus.device_io_read_data, 32'h0000_0008);
        check("irq_before_drop", {31'b0, irq}, 32'h1);
        rd_chk("edge_cleared", 8'h40, 32'h0);
        check("irq_dropped", {31'b0, irq}, 32'h0);

        // new edge coincident with clear: set wins
        btn = 20'h00000;
        repeat (10) tick();
        btn = 20'h00008;
        bus.device_io_addr = 8'h40;
        repeat (6) tick();
        wr(8'h40, 32'h0000_0008);
        rd_chk("edge_set_wins", 8'h40, 32'h0000_0008);
        check("irq_after_set_wins", {31'b0, irq}, 32'h1);

        // timer load and wrap
        wr(8'h60, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("timer_%0d", i), bus.device_io_read_data, timer_exp[i]);
        end

        // writes to read-only and unmapped offsets are ignored
        wr(8'h20, 32'h0000_1234);
        wr(8'h30, 32'h0000_1234);
        wr(8'hA0, 32'h0000_1234);
        rd_chk("sw_ro", 8'h20, 32'h0000_0001);
        rd_chk("btn_ro", 8'h30, 32'h0000_0008);
        rd_chk("unmapped_a0", 8'hA0, 32'h0);
        rd_chk("led_low_nibble", 8'h07, 32'h0000_A5A5);
        rd_chk("seg_keep", 8'h10, 32'h1234_5678);
        rd_chk("irq_en_keep", 8'h50, 32'h0000_0008);
        rd_chk("edge_keep", 8'h40, 32'h0000_0008);
        check("led_out_keep", {16'b0, led_out}, 32'h0000_A5A5);

        wr(8'h50, 32'hFFFF_FFFF);
        rd_chk("irq_en_narrow", 8'h50, 32'h000F_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
